// File: rtl/round_controller_pkg.sv
// Shared types and defaults for the Gold Miner round sequencer.
package round_controller_pkg;

    localparam int TIME_WIDTH  = 8;
    localparam int SCORE_WIDTH = 16;
    localparam int LEVEL_WIDTH = 4;

    localparam int                     DEF_LEVELS        = 4;
    localparam logic [SCORE_WIDTH-1:0] DEF_BASE_TARGET   = 16'd650;
    localparam logic [SCORE_WIDTH-1:0] DEF_TARGET_STEP   = 16'd400;
    localparam logic [TIME_WIDTH-1:0]  DEF_BONUS_PER_SEC = 8'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_BONUS  = 3'd4,
        ST_RESULT = 3'd5,
        ST_OVER   = 3'd6,
        ST_WIN    = 3'd7
    } state_e;

    // Score needed to clear a level; wraps modulo 2^SCORE_WIDTH.
    function automatic logic [SCORE_WIDTH-1:0] level_target(
        input logic [LEVEL_WIDTH-1:0] lvl,
        input logic [SCORE_WIDTH-1:0] base,
        input logic [SCORE_WIDTH-1:0] step
    );
        logic [SCORE_WIDTH-1:0] lvl_ext;
        lvl_ext = {{(SCORE_WIDTH-LEVEL_WIDTH){1'b0}}, lvl};
        return base + lvl_ext * step;
    endfunction

endpackage

// File: rtl/round_controller_if.sv
// Signal bundle between the round controller and the keys/timer/score/object blocks.
interface round_controller_if
    import round_controller_pkg::*;
();
    logic                   start;
    logic                   pause;
    logic                   frame_tick;
    logic                   time_up;
    logic [TIME_WIDTH-1:0]  time_remain;
    logic [SCORE_WIDTH-1:0] score;
    logic                   all_collected;
    logic                   timer_enable;
    logic                   time_resetn;
    logic                   move_enable;
    logic                   score_clear;
    logic                   score_add;
    logic [TIME_WIDTH-1:0]  score_to_add;
    logic [LEVEL_WIDTH-1:0] level;
    logic [2:0]             state;
    logic                   level_pass;
    logic                   game_over;
    logic                   game_win;

    // Environment side: keys, timer, score adder and object manager.
    modport master (
        output start, pause, frame_tick, time_up, time_remain, score, all_collected,
        input  timer_enable, time_resetn, move_enable, score_clear, score_add,
               score_to_add, level, state, level_pass, game_over, game_win
    );

    // Controller side.
    modport slave (
        input  start, pause, frame_tick, time_up, time_remain, score, all_collected,
        output timer_enable, time_resetn, move_enable, score_clear, score_add,
               score_to_add, level, state, level_pass, game_over, game_win
    );
endinterface

// File: rtl/round_controller_key_edge.sv
// Rising-edge detector for a level-sensitive key: one pulse per press.
module key_edge (
    input  logic clk,
    input  logic resetn,
    input  logic key_i,
    output logic pulse_o
);
    logic key_q;

    // Remember last cycle's key sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) key_q <= 1'b0;
        else         key_q <= key_i;
    end

    assign pulse_o = key_i & ~key_q;
endmodule

// File: rtl/round_controller.sv
// Round sequencer: drives timer/motion gating, judges the level target,
// pays out the early-clear time bonus and steps levels to win or game over.
module round_controller
    import round_controller_pkg::*;
#(
    parameter int                     LEVELS        = DEF_LEVELS,
    parameter logic [SCORE_WIDTH-1:0] BASE_TARGET   = DEF_BASE_TARGET,
    parameter logic [SCORE_WIDTH-1:0] TARGET_STEP   = DEF_TARGET_STEP,
    parameter logic [TIME_WIDTH-1:0]  BONUS_PER_SEC = DEF_BONUS_PER_SEC
) (
    input logic              clk,
    input logic              resetn,
    round_controller_if.slave bus
);
    localparam logic [LEVEL_WIDTH-1:0] LAST_LEVEL = LEVEL_WIDTH'(LEVELS - 1);

    state_e                 state_q, state_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [TIME_WIDTH-1:0]  bonus_q, bonus_d;
    logic                   start_p, pause_p;
    logic                   score_clear, score_add;
    logic                   pass;

    key_edge u_start_edge (.clk(clk), .resetn(resetn), .key_i(bus.start), .pulse_o(start_p));
    key_edge u_pause_edge (.clk(clk), .resetn(resetn), .key_i(bus.pause), .pulse_o(pause_p));

    assign pass = (bus.score >= level_target(level_q, BASE_TARGET, TARGET_STEP));

    // State, level and bonus-seconds registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            bonus_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            bonus_q <= bonus_d;
        end
    end

    // Next state plus the two score pulses; each state only listens to its own key.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        bonus_d     = bonus_q;
        score_clear = 1'b0;
        score_add   = 1'b0;
        case (state_q)
            ST_IDLE: if (start_p) begin
                score_clear = 1'b1;
                level_d     = '0;
                state_d     = ST_LOAD;
            end
            ST_LOAD: state_d = ST_PLAY;
            ST_PLAY: begin
                if (bus.all_collected) begin
                    bonus_d = bus.time_remain;
                    state_d = ST_BONUS;
                end else if (bus.time_up) begin
                    state_d = pass ? ST_RESULT : ST_OVER;
                end else if (pause_p) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: if (pause_p) state_d = ST_PLAY;
            ST_BONUS: begin
                // Early clear always passes; drain remaining seconds one per frame.
                if (bonus_q == '0) begin
                    state_d = ST_RESULT;
                end else if (bus.frame_tick) begin
                    score_add = 1'b1;
                    bonus_d   = bonus_q - 1'b1;
                end
            end
            ST_RESULT: if (start_p) begin
                if (level_q == LAST_LEVEL) begin
                    state_d = ST_WIN;
                end else begin
                    level_d = level_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_OVER: if (start_p) state_d = ST_IDLE;
            ST_WIN:  if (start_p) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.timer_enable = (state_q == ST_PLAY);
    assign bus.move_enable  = (state_q == ST_PLAY);
    assign bus.time_resetn  = (state_q != ST_LOAD);
    assign bus.level_pass   = (state_q == ST_RESULT);
    assign bus.game_over    = (state_q == ST_OVER);
    assign bus.game_win     = (state_q == ST_WIN);
    assign bus.state        = state_q;
    assign bus.level        = level_q;
    assign bus.score_clear  = score_clear;
    assign bus.score_add    = score_add;
    assign bus.score_to_add = BONUS_PER_SEC;
endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with an expected-value queue.
module tb_round_controller;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   sc_cnt = 0;
    int   sa_cnt = 0;
    int   trlo_cnt = 0;
    logic [31:0] exp_q[$];

    round_controller_if ifc ();

    round_controller dut (.clk(clk), .resetn(resetn), .bus(ifc.slave));

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (ifc.score_clear) sc_cnt++;
        if (ifc.score_add)   sa_cnt++;
        if (!ifc.time_resetn) trlo_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: got %0d, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: got %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    initial begin
        ifc.start = 0; ifc.pause = 0; ifc.frame_tick = 0; ifc.time_up = 0;
        ifc.time_remain = 8'd60; ifc.score = 16'd0; ifc.all_collected = 0;
        #12;
        // Reset state
        expect_v(0); chk("rst_state", 32'(ifc.state));
        expect_v(0); chk("rst_level", 32'(ifc.level));
        expect_v(1); chk("rst_time_resetn", 32'(ifc.time_resetn));
        expect_v(0); chk("rst_outs", 32'({ifc.timer_enable, ifc.move_enable, ifc.score_clear,
                                          ifc.score_add, ifc.level_pass, ifc.game_over, ifc.game_win}));
        resetn = 1;
        tick();
        trlo_cnt = 0;
        // Start held 5 cycles: single clear, IDLE->LOAD->PLAY
        ifc.start = 1; #1;
        expect_v(1); chk("clear_pulse", 32'(ifc.score_clear));
        tick();
        expect_v(1); chk("load_state", 32'(ifc.state));
        expect_v(0); chk("load_time_resetn", 32'(ifc.time_resetn));
        tick();
        expect_v(2); chk("play_state", 32'(ifc.state));
        expect_v(1); chk("play_time_resetn", 32'(ifc.time_resetn));
        expect_v(3); chk("play_en", 32'({ifc.timer_enable, ifc.move_enable}));
        tick(); tick(); tick();
        ifc.start = 0;
        expect_v(1); chk("clear_count", 32'(sc_cnt));
        expect_v(1); chk("reload_len", 32'(trlo_cnt));
        // Level 0 exact target passes
        ifc.score = 16'd650; ifc.time_up = 1; ifc.time_remain = 0;
        tick(); ifc.time_up = 0;
        expect_v(5); chk("l0_result", 32'(ifc.state));
        expect_v(1); chk("l0_pass", 32'(ifc.level_pass));
        ifc.start = 1; tick(); ifc.start = 0;
        expect_v(1); chk("l1_load", 32'(ifc.state));
        expect_v(1); chk("l1_level", 32'(ifc.level));
        expect_v(1); chk("l1_no_clear", 32'(sc_cnt));
        ifc.time_remain = 8'd60;
        tick();
        expect_v(2); chk("l1_play", 32'(ifc.state));
        // Level 1 one below 1050 fails
        ifc.score = 16'd1049; ifc.time_up = 1;
        tick(); ifc.time_up = 0;
        expect_v(6); chk("l1_over", 32'(ifc.state));
        expect_v(1); chk("over_flag", 32'(ifc.game_over));
        expect_v(0); chk("over_timer", 32'(ifc.timer_enable));
        ifc.start = 1; tick(); ifc.start = 0;
        expect_v(0); chk("over_idle", 32'(ifc.state));
        expect_v(1); chk("idle_level_kept", 32'(ifc.level));
        tick();
        ifc.start = 1; tick(); ifc.start = 0;
        expect_v(0); chk("restart_level", 32'(ifc.level));
        tick();
        expect_v(2); chk("restart_play", 32'(ifc.state));
        // Pause / unpause, start ignored while paused
        ifc.pause = 1; tick(); ifc.pause = 0;
        expect_v(3); chk("pause_state", 32'(ifc.state));
        expect_v(0); chk("pause_en", 32'({ifc.timer_enable, ifc.move_enable}));
        tick();
        ifc.start = 1; tick(); ifc.start = 0;
        expect_v(3); chk("pause_start_ign", 32'(ifc.state));
        ifc.pause = 1; tick(); ifc.pause = 0;
        expect_v(2); chk("unpause", 32'(ifc.state));
        tick();
        // time_up beats pause_p
        ifc.score = 16'd650; ifc.time_up = 1; ifc.pause = 1;
        tick(); ifc.time_up = 0; ifc.pause = 0;
        expect_v(5); chk("tu_beats_pause", 32'(ifc.state));
        ifc.start = 1; tick(); ifc.start = 0; tick();
        expect_v(2); chk("l1b_play", 32'(ifc.state));
        expect_v(1); chk("l1b_level", 32'(ifc.level));
        // Early clear with 3 s left, all_collected beats time_up; score below target
        sa_cnt = 0;
        ifc.score = 16'd100; ifc.all_collected = 1; ifc.time_up = 1; ifc.time_remain = 8'd3;
        tick(); ifc.all_collected = 0; ifc.time_up = 0;
        expect_v(4); chk("bonus_state", 32'(ifc.state));
        tick(); tick();
        expect_v(0); chk("bonus_no_tick", 32'(sa_cnt));
        for (int i = 0; i < 3; i++) begin
            ifc.frame_tick = 1; #1;
            expect_v(1); chk("bonus_add", 32'(ifc.score_add));
            expect_v(10); chk("bonus_amt", 32'(ifc.score_to_add));
            tick(); ifc.frame_tick = 0;
            expect_v(4); chk("bonus_hold", 32'(ifc.state));
            tick();
        end
        expect_v(5); chk("bonus_result", 32'(ifc.state));
        expect_v(3); chk("bonus_count", 32'(sa_cnt));
        // Level 2: early clear with 0 s passes straight through
        ifc.start = 1; tick(); ifc.start = 0; tick();
        ifc.all_collected = 1; ifc.time_remain = 0; ifc.frame_tick = 1;
        tick(); ifc.all_collected = 0; ifc.frame_tick = 0;
        expect_v(4); chk("zero_bonus", 32'(ifc.state));
        tick();
        expect_v(5); chk("zero_result", 32'(ifc.state));
        expect_v(3); chk("zero_no_add", 32'(sa_cnt));
        // Level 3 passes at 1850, then WIN
        ifc.start = 1; tick(); ifc.start = 0; tick();
        expect_v(3); chk("l3_level", 32'(ifc.level));
        ifc.score = 16'd1850; ifc.time_up = 1;
        tick(); ifc.time_up = 0;
        expect_v(5); chk("l3_result", 32'(ifc.state));
        ifc.start = 1; tick(); ifc.start = 0;
        expect_v(7); chk("win_state", 32'(ifc.state));
        expect_v(1); chk("win_flag", 32'(ifc.game_win));
        tick();
        ifc.start = 1; tick(); ifc.start = 0;
        expect_v(0); chk("win_idle", 32'(ifc.state));
        tick();
        // Reset in the middle of a bonus payout
        ifc.start = 1; tick(); ifc.start = 0; tick();
        ifc.all_collected = 1; ifc.time_remain = 8'd5;
        tick(); ifc.all_collected = 0;
        expect_v(4); chk("pre_rst_bonus", 32'(ifc.state));
        #2 resetn = 0; #1;
        expect_v(0); chk("mid_rst_state", 32'(ifc.state));
        expect_v(1); chk("mid_rst_tr", 32'(ifc.time_resetn));
        expect_v(0); chk("mid_rst_outs", 32'({ifc.timer_enable, ifc.move_enable, ifc.score_clear,
                                              ifc.score_add, ifc.level_pass, ifc.game_over,
                                              ifc.game_win, ifc.level}));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
